// File: rtl/oc8051_cxrom_pkg.sv
// Shared constants and B burst state encoding for the oc8051 code-ROM arbiter.
package oc8051_cxrom_pkg;
    localparam int CXROM_ADDR_W = 16;
    localparam int CXROM_DATA_W = 32;
    localparam int CXROM_LEN_W  = 8;
    localparam int CXROM_MAX_AS = 4;

    typedef enum logic {
        B_IDLE = 1'b0,
        B_RUN  = 1'b1
    } b_state_e;
endpackage

// File: rtl/oc8051_cxrom_burst.sv
// Hash-engine burst reader: FSM, address/length counters and the
// backpressured output register.
module oc8051_cxrom_burst
    import oc8051_cxrom_pkg::*;
#(
    parameter int ADDR_W = CXROM_ADDR_W,
    parameter int DATA_W = CXROM_DATA_W,
    parameter int LEN_W  = CXROM_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              b_start,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [LEN_W-1:0]  b_len,
    input  logic              b_ready,
    input  logic              win,
    input  logic [DATA_W-1:0] rom_data,
    output logic              eligible,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              b_busy,
    output logic              b_valid,
    output logic [DATA_W-1:0] b_data,
    output logic              b_done
);
    b_state_e          state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              room;
    logic              fin;

    assign room     = !valid_q || b_ready;
    assign eligible = (state_q == B_RUN) && (rem_q != '0) && room;
    // Completion is reported in the cycle the last word leaves.
    assign fin      = (state_q == B_RUN) && (rem_q == '0) && room;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            B_IDLE: begin
                if (b_start) begin
                    if (b_len != '0) begin
                        state_d = B_RUN;
                        cur_d   = b_addr;
                        rem_d   = b_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            B_RUN: begin
                if (win) begin
                    data_d  = rom_data;
                    valid_d = 1'b1;
                    cur_d   = cur_q + ADDR_W'(1);
                    rem_d   = rem_q - LEN_W'(1);
                end else if (valid_q && b_ready) begin
                    valid_d = 1'b0;
                end
                if (fin) begin
                    state_d = B_IDLE;
                end
            end
            default: state_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= B_IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign cur_addr = cur_q;
    assign b_busy   = (state_q == B_RUN);
    assign b_valid  = valid_q;
    assign b_data   = data_q;
    assign b_done   = done_q || fin;
endmodule

// File: rtl/oc8051_cxrom_arb.sv
// Code-ROM arbiter: priority single-word fetch port A, burst port B with
// a bounded A streak so B cannot starve.
module oc8051_cxrom_arb
    import oc8051_cxrom_pkg::*;
#(
    parameter int ADDR_W       = CXROM_ADDR_W,
    parameter int DATA_W       = CXROM_DATA_W,
    parameter int LEN_W        = CXROM_LEN_W,
    parameter int MAX_A_STREAK = CXROM_MAX_AS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_valid,
    output logic [DATA_W-1:0] a_data,
    input  logic              b_start,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [LEN_W-1:0]  b_len,
    output logic              b_busy,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [DATA_W-1:0] b_data,
    output logic              b_done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);
    localparam int SW = $clog2(MAX_A_STREAK + 1);

    logic              b_elig;
    logic              b_win;
    logic [ADDR_W-1:0] b_cur;
    logic [SW-1:0]     streak_q, streak_d;
    logic              a_valid_q;
    logic [DATA_W-1:0] a_data_q;

    oc8051_cxrom_burst #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_burst (
        .clk      (clk),
        .rst      (rst),
        .b_start  (b_start),
        .b_addr   (b_addr),
        .b_len    (b_len),
        .b_ready  (b_ready),
        .win      (b_win),
        .rom_data (rom_data),
        .eligible (b_elig),
        .cur_addr (b_cur),
        .b_busy   (b_busy),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_done   (b_done)
    );

    assign b_win    = rst && b_elig &&
                      (!a_req || streak_q == SW'(MAX_A_STREAK));
    assign a_gnt    = rst && a_req && !b_win;
    assign rom_addr = !rst ? '0 : (b_win ? b_cur : a_addr);

    always_comb begin
        streak_d = streak_q;
        if (!b_elig || b_win) begin
            streak_d = '0;
        end else if (a_gnt && streak_q != SW'(MAX_A_STREAK)) begin
            streak_d = streak_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q  <= '0;
            a_valid_q <= 1'b0;
            a_data_q  <= '0;
        end else begin
            streak_q  <= streak_d;
            a_valid_q <= a_gnt;
            if (a_gnt) begin
                a_data_q <= rom_data;
            end
        end
    end

    assign a_valid = a_valid_q;
    assign a_data  = a_data_q;
endmodule

// File: tb/tb_oc8051_cxrom_arb.sv
// Directed bench for oc8051_cxrom_arb with a behavioural combinational ROM.
module tb_oc8051_cxrom_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_req = 1'b0;
    logic [15:0] a_addr = '0;
    logic        a_gnt;
    logic        a_valid;
    logic [31:0] a_data;
    logic        b_start = 1'b0;
    logic [15:0] b_addr = '0;
    logic [7:0]  b_len = '0;
    logic        b_busy;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic [31:0] b_data;
    logic        b_done;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;

    int errs = 0;
    int checks = 0;

    function automatic logic [31:0] rom_f(input logic [15:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    assign rom_data = rom_f(rom_addr);

    always #5 clk = ~clk;

    oc8051_cxrom_arb dut (
        .clk      (clk),
        .rst      (rst),
        .a_req    (a_req),
        .a_addr   (a_addr),
        .a_gnt    (a_gnt),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .b_start  (b_start),
        .b_addr   (b_addr),
        .b_len    (b_len),
        .b_busy   (b_busy),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .b_done   (b_done),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    task automatic test_reset();
        a_req  = 1'b1;
        a_addr = 16'h0033;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({a_gnt, a_valid, b_valid, b_busy, b_done} !== 5'b0) begin
            $display("FAIL reset_flags got=%b exp=00000",
                     {a_gnt, a_valid, b_valid, b_busy, b_done});
            errs++;
        end
        checks++;
        if (rom_addr !== 16'h0 || a_data !== 32'h0 || b_data !== 32'h0) begin
            $display("FAIL reset_data rom_addr=%h a_data=%h b_data=%h exp=0",
                     rom_addr, a_data, b_data);
            errs++;
        end
        @(negedge clk);
        rst   = 1'b1;
        a_req = 1'b0;
    endtask

    task automatic test_a_only();
        @(negedge clk);
        a_req  = 1'b1;
        a_addr = 16'h0010;
        #1;
        checks++;
        if (a_gnt !== 1'b1 || rom_addr !== 16'h0010) begin
            $display("FAIL a_grant got gnt=%b addr=%h exp 1 0010",
                     a_gnt, rom_addr);
            errs++;
        end
        @(negedge clk);
        a_req = 1'b0;
        #1;
        checks++;
        if (a_valid !== 1'b1 || a_data !== rom_f(16'h0010)) begin
            $display("FAIL a_data got v=%b d=%h exp 1 %h",
                     a_valid, a_data, rom_f(16'h0010));
            errs++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (a_valid !== 1'b0 || a_data !== rom_f(16'h0010)) begin
            $display("FAIL a_hold got v=%b d=%h exp 0 %h",
                     a_valid, a_data, rom_f(16'h0010));
            errs++;
        end
    endtask

    task automatic test_b_only();
        @(negedge clk);
        b_start = 1'b1;
        b_addr  = 16'h0200;
        b_len   = 8'd4;
        b_ready = 1'b1;
        #1;
        checks++;
        if (b_busy !== 1'b0) begin
            $display("FAIL b_busy_start got=%b exp=0", b_busy);
            errs++;
        end
        @(negedge clk);
        b_start = 1'b0;
        #1;
        checks++;
        if (b_busy !== 1'b1 || rom_addr !== 16'h0200) begin
            $display("FAIL b_first got busy=%b addr=%h exp 1 0200",
                     b_busy, rom_addr);
            errs++;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (b_valid !== 1'b1 || b_data !== rom_f(16'h0200 + 16'(i)) ||
                b_done !== (i == 3)) begin
                $display("FAIL b_word%0d got v=%b d=%h done=%b exp 1 %h %b",
                         i, b_valid, b_data, b_done,
                         rom_f(16'h0200 + 16'(i)), (i == 3));
                errs++;
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({b_busy, b_valid, b_done} !== 3'b000) begin
            $display("FAIL b_end got busy/valid/done=%b exp=000",
                     {b_busy, b_valid, b_done});
            errs++;
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        @(negedge clk);
        a_addr  = 16'h0055;
        b_start = 1'b1;
        b_addr  = 16'h0200;
        b_len   = 8'd4;
        b_ready = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_ready = 1'b0;
            #1;
            checks++;
            if (b_valid !== 1'b1 || b_data !== rom_f(16'h0200) ||
                rom_addr !== 16'h0055) begin
                $display("FAIL bp_hold%0d got v=%b d=%h addr=%h exp 1 %h 0055",
                         i, b_valid, b_data, rom_addr, rom_f(16'h0200));
                errs++;
            end
        end
        @(negedge clk);
        b_ready = 1'b1;
        #1;
        checks++;
        if (rom_addr !== 16'h0201) begin
            $display("FAIL bp_resume_addr got=%h exp=0201", rom_addr);
            errs++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (b_valid !== 1'b1 || b_data !== rom_f(16'h0201)) begin
            $display("FAIL bp_resume_data got v=%b d=%h exp 1 %h",
                     b_valid, b_data, rom_f(16'h0201));
            errs++;
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (b_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            $display("FAIL bp_done got=timeout exp=b_done pulse");
            errs++;
        end
    endtask

    task automatic test_starve_wrap();
        logic [15:0] ea;
        @(negedge clk);
        a_req   = 1'b1;
        a_addr  = 16'h0000;
        b_start = 1'b1;
        b_addr  = 16'hFFFE;
        b_len   = 8'd3;
        b_ready = 1'b1;
        #1;
        checks++;
        if (a_gnt !== 1'b1) begin
            $display("FAIL st_start got gnt=%b exp=1", a_gnt);
            errs++;
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            b_start = 1'b0;
            #1;
            if (i % 5 == 4) begin
                ea = 16'hFFFE + 16'(i / 5);
                checks++;
                if (a_gnt !== 1'b0 || rom_addr !== ea) begin
                    $display("FAIL st_b%0d got gnt=%b addr=%h exp 0 %h",
                             i, a_gnt, rom_addr, ea);
                    errs++;
                end
            end else begin
                checks++;
                if (a_gnt !== 1'b1 || rom_addr !== 16'h0000) begin
                    $display("FAIL st_a%0d got gnt=%b addr=%h exp 1 0000",
                             i, a_gnt, rom_addr);
                    errs++;
                end
            end
            if (i % 5 == 0 && i > 0) begin
                ea = 16'hFFFE + 16'(i / 5 - 1);
                checks++;
                if (b_valid !== 1'b1 || b_data !== rom_f(ea)) begin
                    $display("FAIL st_bdata%0d got v=%b d=%h exp 1 %h",
                             i, b_valid, b_data, rom_f(ea));
                    errs++;
                end
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (b_done !== 1'b1 || b_data !== rom_f(16'h0000) || a_gnt !== 1'b1) begin
            $display("FAIL st_done got done=%b d=%h gnt=%b exp 1 %h 1",
                     b_done, b_data, a_gnt, rom_f(16'h0000));
            errs++;
        end
        @(negedge clk);
        b_start = 1'b1;
        b_len   = 8'd0;
        #1;
        checks++;
        if (b_done !== 1'b0 || b_busy !== 1'b0) begin
            $display("FAIL z_issue got done=%b busy=%b exp 0 0", b_done, b_busy);
            errs++;
        end
        @(negedge clk);
        b_start = 1'b0;
        #1;
        checks++;
        if (b_done !== 1'b1 || b_busy !== 1'b0 || a_gnt !== 1'b1 ||
            rom_addr !== 16'h0000) begin
            $display("FAIL z_done got done=%b busy=%b gnt=%b addr=%h exp 1 0 1 0000",
                     b_done, b_busy, a_gnt, rom_addr);
            errs++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (b_done !== 1'b0) begin
            $display("FAIL z_pulse got done=%b exp=0", b_done);
            errs++;
        end
        a_req = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        b_start = 1'b1;
        b_addr  = 16'h0100;
        b_len   = 8'd8;
        b_ready = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (b_valid !== 1'b1 || b_data !== rom_f(16'h0102)) begin
            $display("FAIL rm_pre got v=%b d=%h exp 1 %h",
                     b_valid, b_data, rom_f(16'h0102));
            errs++;
        end
        @(negedge clk);
        rst    = 1'b0;
        a_req  = 1'b1;
        a_addr = 16'h0010;
        #1;
        checks++;
        if ({a_gnt, a_valid, b_valid, b_busy, b_done} !== 5'b0 ||
            rom_addr !== 16'h0 || a_data !== 32'h0 || b_data !== 32'h0) begin
            $display("FAIL rm_clear got flags=%b addr=%h ad=%h bd=%h exp 0",
                     {a_gnt, a_valid, b_valid, b_busy, b_done},
                     rom_addr, a_data, b_data);
            errs++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (b_done !== 1'b0 || b_busy !== 1'b0) begin
            $display("FAIL rm_hold got done=%b busy=%b exp 0 0", b_done, b_busy);
            errs++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (b_busy !== 1'b0 || b_done !== 1'b0 || a_gnt !== 1'b1 ||
            rom_addr !== 16'h0010) begin
            $display("FAIL rm_release got busy=%b done=%b gnt=%b addr=%h exp 0 0 1 0010",
                     b_busy, b_done, a_gnt, rom_addr);
            errs++;
        end
        @(negedge clk);
        a_req = 1'b0;
        #1;
        checks++;
        if (a_valid !== 1'b1 || a_data !== rom_f(16'h0010) || b_valid !== 1'b0) begin
            $display("FAIL rm_a_serve got v=%b d=%h bv=%b exp 1 %h 0",
                     a_valid, a_data, b_valid, rom_f(16'h0010));
            errs++;
        end
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_b_only();
        test_backpressure();
        test_starve_wrap();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
